// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC core.
// Angles are binary: 2^31 in the table equals pi.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

  localparam logic ROTATE = 1'b0;
  localparam logic VECTOR = 1'b1;

  localparam int CNT_W = 5;

  localparam logic [31:0] ATAN_TABLE [0:23] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
    32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
    32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051
  };

  // Top w bits of the table entry, rounded to nearest.
  function automatic logic [31:0] atan_scaled(input int i, input int w);
    logic [31:0] r;
    r = ATAN_TABLE[i[4:0]] + (32'd1 << (31 - w));
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// Combinational CORDIC micro-rotation.
// Shifts are arithmetic and truncating.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW = 10,
  parameter int ZW = 8
) (
  input  logic signed [XW-1:0]    x,
  input  logic signed [XW-1:0]    y,
  input  logic signed [ZW-1:0]    z,
  input  logic        [CNT_W-1:0] shift,
  input  logic signed [ZW-1:0]    atan,
  input  logic                    mode,
  output logic signed [XW-1:0]    x_next,
  output logic signed [XW-1:0]    y_next,
  output logic signed [ZW-1:0]    z_next
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic                 pos;

  assign xs  = x >>> shift;
  assign ys  = y >>> shift;
  assign pos = (mode == ROTATE) ? ~z[ZW-1] : y[XW-1];

  always_comb begin
    if (pos) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC: quadrant pre-rotation, then one
// micro-rotation per clock; start/busy/done handshake.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITERS = 8,
  parameter int GUARD = 2
) (
  input  logic                           clka,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cordic_mode,
  input  logic signed [WIDTH-1:0]        x_in,
  input  logic signed [WIDTH-1:0]        y_in,
  input  logic signed [WIDTH-1:0]        z_in,
  output logic signed [WIDTH+GUARD-1:0]  x_out,
  output logic signed [WIDTH+GUARD-1:0]  y_out,
  output logic signed [WIDTH-1:0]        z_out,
  output logic                           busy,
  output logic                           done
);

  localparam int XW = WIDTH + GUARD;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  localparam logic signed [WIDTH-1:0] QUARTER =
    {2'b01, {(WIDTH-2){1'b0}}};

  state_t state;
  state_t state_n;

  logic signed [XW-1:0]    x_cap;
  logic signed [XW-1:0]    y_cap;
  logic signed [WIDTH-1:0] z_cap;
  logic                    mode_r;
  logic [CNT_W-1:0]        cnt;

  logic signed [XW-1:0]    x_pre;
  logic signed [XW-1:0]    y_pre;
  logic signed [WIDTH-1:0] z_pre;
  logic signed [XW-1:0]    x_nx;
  logic signed [XW-1:0]    y_nx;
  logic signed [WIDTH-1:0] z_nx;
  logic signed [WIDTH-1:0] atan_cur;
  logic signed [WIDTH-1:0] atan_lut [ITERS];

  logic accept;
  logic vec;
  logic neg_x;
  logic neg_y;
  logic z_hi;
  logic z_lo;

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == LOAD) || (state == ITER);
  assign done   = (state == DONE);

  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    localparam logic [31:0] A = atan_scaled(g, WIDTH);
    assign atan_lut[g] = A[WIDTH-1:0];
  end

  always_comb begin
    atan_cur = '0;
    for (int k = 0; k < ITERS; k++) begin
      if (cnt == k[CNT_W-1:0]) atan_cur = atan_lut[k];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD;
      DONE:    if (start) state_n = LOAD;
      LOAD:    state_n = ITER;
      ITER:    if (cnt == LAST) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Fold the operand into the right half-plane (vectoring)
  // or into [-pi/2, pi/2) (rotation).
  assign vec   = (mode_r == VECTOR);
  assign neg_x = x_cap[XW-1];
  assign neg_y = y_cap[XW-1];
  assign z_hi  = ~z_cap[WIDTH-1] & z_cap[WIDTH-2];
  assign z_lo  = z_cap[WIDTH-1] & ~z_cap[WIDTH-2];

  always_comb begin
    x_pre = x_cap;
    y_pre = y_cap;
    z_pre = z_cap;
    unique case (1'b1)
      vec && neg_x && !neg_y: begin
        x_pre = y_cap;
        y_pre = -x_cap;
        z_pre = z_cap + QUARTER;
      end
      vec && neg_x && neg_y: begin
        x_pre = -y_cap;
        y_pre = x_cap;
        z_pre = z_cap - QUARTER;
      end
      !vec && z_hi: begin
        x_pre = -y_cap;
        y_pre = x_cap;
        z_pre = z_cap - QUARTER;
      end
      !vec && z_lo: begin
        x_pre = y_cap;
        y_pre = -x_cap;
        z_pre = z_cap + QUARTER;
      end
      default: ;
    endcase
  end

  cordic_stage #(
    .XW(XW),
    .ZW(WIDTH)
  ) u_stage (
    .x      (x_out),
    .y      (y_out),
    .z      (z_out),
    .shift  (cnt),
    .atan   (atan_cur),
    .mode   (mode_r),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  always_ff @(posedge clka) begin
    if (reset) begin
      x_cap  <= '0;
      y_cap  <= '0;
      z_cap  <= '0;
      mode_r <= ROTATE;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        x_cap  <= {{GUARD{x_in[WIDTH-1]}}, x_in};
        y_cap  <= {{GUARD{y_in[WIDTH-1]}}, y_in};
        z_cap  <= z_in;
        mode_r <= cordic_mode;
      end
      unique case (state)
        LOAD: begin
          x_out <= x_pre;
          y_out <= y_pre;
          z_out <= z_pre;
          cnt   <= '0;
        end
        ITER: begin
          x_out <= x_nx;
          y_out <= y_nx;
          z_out <= z_nx;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cordic_iter.md
Name: cordic_iter

Overview:
- Parametrised, single-clock successor to the 8-bit two-phase CORDIC.
- Iterative core: one micro-rotation per cycle, rotation and vectoring modes, start/busy/done handshake.
- New versus the previous generation: configurable WIDTH and ITERS, and a quadrant pre-rotation that gives full-circle angle and vector coverage.
- Sits between the operand registers/bus interface and downstream consumers of (x, y, z).

Parameters:
- WIDTH, 8, input/angle word width (legal 8..24).
- ITERS, 8, micro-rotation count (legal 1..WIDTH).
- GUARD, 2, extra MSBs on x/y paths to absorb CORDIC gain (~1.647) and the sqrt(2) growth.

Ports:
- clka  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- cordic_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled with start.
- x_in  in  WIDTH  signed.
- y_in  in  WIDTH  signed.
- z_in  in  WIDTH  signed binary angle, LSB = pi/2^(WIDTH-1), range [-pi, pi).
- x_out  out  WIDTH+GUARD  signed, registered.
- y_out  out  WIDTH+GUARD  signed, registered.
- z_out  out  WIDTH  signed binary angle, registered.
- busy  out  1  high in LOAD and ITER.
- done  out  1  high in DONE, held until the next accepted start or reset.

Behaviour:
- Interface: one clock, clka; reset is synchronous and active-high.
- Reset (any state, including mid-operation): state goes to IDLE; x_out, y_out, z_out, busy, done all 0; iteration counter 0. No partial result is retained.
- FSM states:
  - IDLE: on start, capture inputs sign-extended to WIDTH+GUARD, latch mode, go to LOAD.
  - LOAD: apply quadrant pre-rotation, counter = 0, go to ITER.
  - ITER: one micro-rotation per cycle; after iteration ITERS-1, go to DONE.
  - DONE: outputs valid and stable; on start, behave as IDLE (capture inputs, go to LOAD, done drops the next cycle).
- start while busy is ignored; no queueing.
- Latency: start sampled at edge N gives done=1 after edge N+ITERS+1; busy is high for ITERS+1 cycles.
- Pre-rotation, rotation mode; Q = pi/2 = 2^(WIDTH-2):
  - z in [Q, pi): (x, y) <- (-y, x), z -= Q.
  - z < -Q: (x, y) <- (y, -x), z += Q.
  - Otherwise unchanged.
- Pre-rotation, vectoring mode:
  - x < 0 and y >= 0: (x, y) <- (y, -x), z += Q.
  - x < 0 and y < 0: (x, y) <- (-y, x), z -= Q.
  - Otherwise unchanged.
- Micro-rotation i:
  - Direction d = +1 if (rotation: z >= 0) or (vectoring: y < 0); else d = -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - >>> is arithmetic shift; results are truncated, with no rounding.
- z arithmetic wraps modulo 2^WIDTH, so pi and -pi alias to -2^(WIDTH-1).
- x/y never overflow for any legal input when GUARD = 2.
- Gain is not compensated. Outputs carry the factor K_ITERS (about 1.6468 for ITERS >= 8).
- Outputs update only on the LOAD to ITER to DONE path. In IDLE they hold their last value (0 after reset). Intermediate values appear on x_out, y_out and z_out while busy; consumers qualify on done.

Decomposition:
- Package cordic_pkg:
  - ATAN_TABLE: 32-bit binary-angle atan(2^-i) for i = 0..23, scaled so that 2^31 = pi.
  - Function atan_scaled(i, WIDTH): top WIDTH bits, round-to-nearest.
  - State enum: IDLE, LOAD, ITER, DONE.
  - Mode constants: ROTATE = 0, VECTOR = 1.
- Sub-module cordic_stage: combinational micro-rotation, parametrised by width. Inputs x, y, z, shift amount, atan constant, mode. Outputs x', y', z'. The top level holds the FSM, counter, pre-rotation and registers.

Test Plan (WIDTH=8, ITERS=8, GUARD=2; tolerance ±2 LSB on x/y, ±1 on z):
- Rotation: x=100, y=0, z=0 -> x_out~164, y_out~0, z_out~0; done exactly 9 cycles after start; busy high for 9 cycles.
- Rotation with pre-rotation: x=100, y=0, z=64 (90 deg) -> x_out~0, y_out~164, z_out~0.
- Vectoring: x=100, y=100, z=0 -> x_out~233, y_out~0, z_out~32 (45 deg).
- Vectoring with wrap: x=-100, y=0, z=0 -> pre-rotation adds +64, iterations add ~+64; z_out = -128 (±pi alias), x_out~164, y_out~0.
- Handshake:
  - start pulsed again at the 3rd busy cycle -> ignored; result is unchanged.
  - start in DONE -> done falls the next cycle; the new result arrives 9 cycles later.
- Reset mid-ITER (cycle 4) -> next cycle state IDLE, all outputs 0, done=0; a fresh start then completes normally.
